mul_sequencer: RTL and testbench

- Iterative shift-add multiply unit for the multicycle ARM core's MUL instruction (register operands only, no immediates).
- The main FSM launches it with a one-cycle Start, holds in its execute state until Done, then writes Result through the normal writeback path.
- Produces the low WIDTH bits of the product plus N/Z flag values.
- Never updates C/V.

---
 rtl/mul_pkg.sv | 20 ++
 rtl/mul_sequencer_if.sv | 41 ++++
 rtl/mul_sequencer.sv | 125 ++++++++++++
 tb/tb_mul_sequencer.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// -----------------------------------------------------------------------------
// mul_pkg
// Shared definitions for the iterative multiply unit and the core decoder.
//   MUL_WIDTH   : default operand/result width.
//   ALU_MUL     : ALUControl code the decoder emits for MUL.
//   mul_state_e : sequencer state encoding (IDLE / RUN / DONE).
// -----------------------------------------------------------------------------
package mul_pkg;

    localparam int MUL_WIDTH = 32;

    localparam logic [2:0] ALU_MUL = 3'b110;

    typedef enum logic [1:0] {
        MS_IDLE = 2'b00,
        MS_RUN  = 2'b01,
        MS_DONE = 2'b10
    } mul_state_e;

endpackage

// File: rtl/mul_sequencer_if.sv
// -----------------------------------------------------------------------------
// mul_sequencer_if
// Request/response bundle between the core's main FSM (master) and the
// multiply sequencer (slave).
//   master drives : Start, SrcA, SrcB, SetFlags
//   slave drives  : Busy, Done, Result, FlagN, FlagZ, FlagWNZ
//
// Handshake: Start is a one-shot request, not a valid/ready pair. It is
// accepted only on a cycle where the unit is idle (Busy=0 and Done=0); SrcA,
// SrcB and SetFlags are captured on that same edge. A Start seen while Busy or
// Done is high is dropped. Done is a single-cycle completion pulse with Result
// and the flags valid; Result stays put until the next accepted Start.
// -----------------------------------------------------------------------------
interface mul_sequencer_if
    import mul_pkg::*;
#(
    parameter int WIDTH = MUL_WIDTH
);

    logic             Start;
    logic [WIDTH-1:0] SrcA;
    logic [WIDTH-1:0] SrcB;
    logic             SetFlags;
    logic             Busy;
    logic             Done;
    logic [WIDTH-1:0] Result;
    logic             FlagN;
    logic             FlagZ;
    logic             FlagWNZ;

    modport master (
        output Start, SrcA, SrcB, SetFlags,
        input  Busy, Done, Result, FlagN, FlagZ, FlagWNZ
    );

    modport slave (
        input  Start, SrcA, SrcB, SetFlags,
        output Busy, Done, Result, FlagN, FlagZ, FlagWNZ
    );

endinterface

// File: rtl/mul_sequencer.sv
// -----------------------------------------------------------------------------
// mul_sequencer
// Iterative shift-add multiplier for the MUL instruction. Produces the low
// WIDTH bits of SrcA*SrcB, plus N/Z flag values and an N/Z write enable.
// C/V are never touched by this unit.
//
// Ports:
//   clk       : system clock, rising edge
//   reset     : synchronous, active-high
//   bus       : mul_sequencer_if.slave (Start/SrcA/SrcB/SetFlags in,
//               Busy/Done/Result/FlagN/FlagZ/FlagWNZ out)
//   state_dbg : current FSM state, for observation only
//
// Build option:
//   MUL_EARLY_EXIT_EN : when defined, RUN also ends as soon as the remaining
//                       multiplier bits are all zero, so latency depends on
//                       the highest set bit of SrcB. Default: fixed WIDTH
//                       RUN cycles.
// -----------------------------------------------------------------------------
module mul_sequencer
    import mul_pkg::*;
#(
    parameter int WIDTH = MUL_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    mul_sequencer_if.slave        bus,
    output mul_state_e            state_dbg
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    mul_state_e       state_q, state_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             sflag_q, sflag_d;

    logic [WIDTH-1:0] acc_step;
    logic [WIDTH-1:0] mplier_shift;
    logic             last_step;

    // One shift-add step; the add wraps mod 2^WIDTH.
    assign acc_step     = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    assign mplier_shift = mplier_q >> 1;

`ifdef MUL_EARLY_EXIT_EN
    // Nothing left to add once the shifted multiplier is empty.
    assign last_step = (count_q == LAST_CNT) || (mplier_shift == '0);
`else
    assign last_step = (count_q == LAST_CNT);
`endif

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        result_d = result_q;
        count_d  = count_q;
        sflag_d  = sflag_q;

        case (state_q)
            MS_IDLE: begin
                if (bus.Start) begin
                    mcand_d  = bus.SrcA;
                    mplier_d = bus.SrcB;
                    acc_d    = '0;
                    count_d  = '0;
                    sflag_d  = bus.SetFlags;
                    state_d  = MS_RUN;
                end
            end
            MS_RUN: begin
                acc_d    = acc_step;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_shift;
                count_d  = count_q + CNT_W'(1);
                if (last_step) begin
                    // Result takes this cycle's add, not the stale acc_q.
                    result_d = acc_step;
                    state_d  = MS_DONE;
                end
            end
            MS_DONE: begin
                state_d = MS_IDLE;
            end
            default: begin
                state_d = MS_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= MS_IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            result_q <= '0;
            count_q  <= '0;
            sflag_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            count_q  <= count_d;
            sflag_q  <= sflag_d;
        end
    end

    assign bus.Busy    = (state_q == MS_RUN);
    assign bus.Done    = (state_q == MS_DONE);
    assign bus.Result  = result_q;
    assign bus.FlagN   = result_q[WIDTH-1];
    assign bus.FlagZ   = (result_q == '0);
    assign bus.FlagWNZ = sflag_q && (state_q == MS_DONE);
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_mul_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mul_sequencer
// Directed bench for mul_sequencer (WIDTH=32). Expected products are
// hand-computed constants; latency follows the build option.
// -----------------------------------------------------------------------------
module tb_mul_sequencer;
    import mul_pkg::*;

    localparam int W = 32;

    logic       clk;
    logic       reset;
    mul_state_e state_dbg;

    mul_sequencer_if #(.WIDTH(W)) bus ();

    mul_sequencer #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    int tests_run    = 0;
    int tests_failed = 0;
    logic [W-1:0] exp_q[$];

    task automatic check_val(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Cycles from the Start cycle to the Done cycle.
    function automatic int exp_latency(input logic [W-1:0] b);
        int hi;
        hi = 0;
        for (int i = 0; i < W; i++) if (b[i]) hi = i;
`ifdef MUL_EARLY_EXIT_EN
        return hi + 2;
`else
        if (hi < 0) return 0;
        return W + 1;
`endif
    endfunction

    // ---------------- driver tasks ----------------
    // Start is raised for exactly one edge; afterwards the operand inputs are
    // scrambled so any late sampling shows up as a wrong product.
    task automatic issue_start(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        @(negedge clk);
        bus.Start    = 1'b1;
        bus.SrcA     = a;
        bus.SrcB     = b;
        bus.SetFlags = s;
        @(negedge clk);
        bus.Start    = 1'b0;
        bus.SrcA     = $urandom;
        bus.SrcB     = $urandom;
        bus.SetFlags = 1'($urandom_range(0, 1));
    endtask

    // Waits (bounded) for Done, counting from the given cycle index.
    task automatic wait_done(input int from, output int lat);
        lat = from;
        while (!bus.Done && lat < 100) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic count_dones(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (bus.Done) n++;
        end
    endtask

    task automatic run_mul(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic s, input logic [W-1:0] exp_res);
        int lat;
        logic [W-1:0] r;
        exp_q.push_back(exp_res);
        issue_start(a, b, s);
        wait_done(1, lat);
        check_val({tag, "_done"}, W'(bus.Done), 1);
        check_val({tag, "_lat"}, W'(lat), W'(exp_latency(b)));
        r = exp_q.pop_front();
        check_val({tag, "_res"}, bus.Result, r);
        check_val({tag, "_n"}, W'(bus.FlagN), W'(r[W-1]));
        check_val({tag, "_z"}, W'(bus.FlagZ), W'(r == '0));
        check_val({tag, "_wnz"}, W'(bus.FlagWNZ), W'(s));
        @(negedge clk);
        check_val({tag, "_done_off"}, W'(bus.Done), 0);
        check_val({tag, "_wnz_off"}, W'(bus.FlagWNZ), 0);
        check_val({tag, "_busy_off"}, W'(bus.Busy), 0);
        check_val({tag, "_res_hold"}, bus.Result, r);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int lat;
        int n;

        bus.Start    = 1'b0;
        bus.SrcA     = '0;
        bus.SrcB     = '0;
        bus.SetFlags = 1'b0;
        reset        = 1'b1;
        repeat (3) @(negedge clk);

        check_val("rst_busy", W'(bus.Busy), 0);
        check_val("rst_done", W'(bus.Done), 0);
        check_val("rst_res", bus.Result, 0);
        check_val("rst_n", W'(bus.FlagN), 0);
        check_val("rst_z", W'(bus.FlagZ), 1);
        check_val("rst_wnz", W'(bus.FlagWNZ), 0);
        check_val("rst_state", W'(state_dbg), W'(MS_IDLE));
        reset = 1'b0;

        run_mul("m3x5", 32'd3, 32'd5, 1'b1, 32'd15);
        run_mul("mff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h0000_0001);
        run_mul("m64k", 32'h0001_0000, 32'h0001_0000, 1'b1, 32'h0000_0000);
        run_mul("msign", 32'h8000_0000, 32'h0000_0001, 1'b1, 32'h8000_0000);
        run_mul("mb0", 32'd5, 32'd0, 1'b1, 32'd0);
        run_mul("m11x4", 32'd11, 32'd4, 1'b0, 32'd44);

`ifndef MUL_EARLY_EXIT_EN
        // Start pulsed mid-RUN must be dropped.
        issue_start(32'd7, 32'd9, 1'b0);
        repeat (9) @(negedge clk);
        check_val("ign_busy", W'(bus.Busy), 1);
        bus.Start = 1'b1;
        bus.SrcA  = 32'd2;
        bus.SrcB  = 32'd2;
        @(negedge clk);
        bus.Start = 1'b0;
        wait_done(11, lat);
        check_val("ign_done", W'(bus.Done), 1);
        check_val("ign_lat", W'(lat), W'(exp_latency(32'd9)));
        check_val("ign_res", bus.Result, 32'd63);
        @(negedge clk);
        check_val("ign_busy_off", W'(bus.Busy), 0);
        count_dones(40, n);
        check_val("ign_extra_done", W'(n), 0);

        // Reset mid-operation discards the partial product.
        issue_start(32'd6, 32'd7, 1'b1);
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_val("mrst_busy", W'(bus.Busy), 0);
        check_val("mrst_done", W'(bus.Done), 0);
        check_val("mrst_res", bus.Result, 0);
        check_val("mrst_z", W'(bus.FlagZ), 1);
        count_dones(40, n);
        check_val("mrst_no_done", W'(n), 0);
`endif

        run_mul("m6x7", 32'd6, 32'd7, 1'b1, 32'd42);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
